// File: rtl/seq_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_frame_pkg
// Description : Shared types and default framing constants for the serial
//               frame transmitter and the "101" detector benches.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_frame_pkg;

  // Frame phases of the transmitter.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    DATA  = 2'd2,
    GUARD = 2'd3
  } state_t;

  // Default framing shared with the detector testbenches.
  localparam int                         c_def_data_w    = 8;
  localparam int                         c_def_pre_len   = 3;
  localparam logic [c_def_pre_len-1:0]   c_def_preamble  = 3'b101;
  localparam int                         c_def_guard_len = 3;

  // Largest of three lengths; sizes the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_piso.sv
`default_nettype none
// ============================================================================
// Module      : seq_piso
// Description : DATA_W-bit parallel-load, MSB-first shift register with
//               separate load and shift enables (load has priority).
// Revision    : 1.0 - initial release
// ============================================================================
module seq_piso #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] d,
  output logic              msb
);

  logic [DATA_W-1:0] r_q;

  // Load a new word, or move the next bit up to the MSB position.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= d;
    end else if (shift) begin
      r_q <= r_q << 1;
    end
  end

  assign msb = r_q[DATA_W-1];

endmodule
`default_nettype wire

// File: rtl/seq_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : seq_frame_tx
// Description : Serial frame transmitter. Accepts a word over valid/ready and
//               sends preamble, payload (MSB first) and a zero guard interval
//               on a single registered bit line.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_frame_tx
  import seq_frame_pkg::*;
#(
  parameter int                 DATA_W    = c_def_data_w,
  parameter int                 PRE_LEN   = c_def_pre_len,
  parameter logic [PRE_LEN-1:0] PREAMBLE  = PRE_LEN'(c_def_preamble),
  parameter int                 GUARD_LEN = c_def_guard_len
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              bit_out,
  output logic              bit_en,
  output logic              busy,
  output logic              done
);

  localparam int                 c_cnt_w      = $clog2(max3(PRE_LEN, DATA_W, GUARD_LEN) + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_pre_last   = c_cnt_w'(PRE_LEN - 1);
  localparam logic [c_cnt_w-1:0] c_data_last  = c_cnt_w'(DATA_W - 1);
  localparam logic [c_cnt_w-1:0] c_guard_last = c_cnt_w'(GUARD_LEN - 1);

  state_t               r_state;
  state_t               w_state_n;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_cnt_n;
  logic                 r_bit_out;
  logic                 r_bit_en;
  logic                 r_done;
  logic                 w_bit_out_n;
  logic                 w_bit_en_n;
  logic                 w_done_n;
  logic                 w_load;
  logic                 w_shift;
  logic                 w_accept;
  logic                 w_pre_bit;
  logic                 w_msb;

  // Payload shift register; the FSM loads it on accept and shifts as bits go out.
  seq_piso #(
    .DATA_W (DATA_W)
  ) u_piso (
    .clk   (clk),
    .reset (reset),
    .load  (w_load),
    .shift (w_shift),
    .d     (in_data),
    .msb   (w_msb)
  );

  // Preamble bit for the next PRE cycle (index r_cnt+1), with constant indices only.
  always_comb begin
    w_pre_bit = 1'b0;
    for (int i = 1; i < PRE_LEN; i++) begin
      if (r_cnt == c_cnt_w'(i - 1)) begin
        w_pre_bit = PREAMBLE[PRE_LEN-1-i];
      end
    end
  end

  // Next state and next registered outputs: each output register holds the bit
  // belonging to the state/count being entered, so the line is never a cycle late.
  always_comb begin
    w_accept    = in_valid && (r_state == IDLE);
    w_state_n   = r_state;
    w_cnt_n     = r_cnt;
    w_bit_out_n = 1'b0;
    w_bit_en_n  = 1'b0;
    w_done_n    = 1'b0;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_n   = PRE;
          w_cnt_n     = '0;
          w_load      = 1'b1;
          w_bit_out_n = PREAMBLE[PRE_LEN-1];
          w_bit_en_n  = 1'b1;
        end
      end
      PRE: begin
        w_bit_en_n = 1'b1;
        if (r_cnt == c_pre_last) begin
          w_state_n   = DATA;
          w_cnt_n     = '0;
          w_bit_out_n = w_msb;
          w_shift     = 1'b1;
        end else begin
          w_cnt_n     = r_cnt + c_cnt_one;
          w_bit_out_n = w_pre_bit;
        end
      end
      DATA: begin
        w_bit_en_n = 1'b1;
        if (r_cnt == c_data_last) begin
          w_state_n = GUARD;
          w_cnt_n   = '0;
        end else begin
          w_cnt_n     = r_cnt + c_cnt_one;
          w_bit_out_n = w_msb;
          w_shift     = 1'b1;
        end
      end
      GUARD: begin
        if (r_cnt == c_guard_last) begin
          w_state_n = IDLE;
          w_cnt_n   = '0;
          w_done_n  = 1'b1;
        end else begin
          w_cnt_n    = r_cnt + c_cnt_one;
          w_bit_en_n = 1'b1;
        end
      end
      default: begin
        w_state_n = IDLE;
        w_cnt_n   = '0;
      end
    endcase
  end

  // State, counter and output registers; reset clears the line immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_out <= 1'b0;
      r_bit_en  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_bit_out <= w_bit_out_n;
      r_bit_en  <= w_bit_en_n;
      r_done    <= w_done_n;
    end
  end

  assign bit_out  = r_bit_out;
  assign bit_en   = r_bit_en;
  assign done     = r_done;
  assign in_ready = (r_state == IDLE);
  assign busy     = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_seq_frame_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_seq_frame_tx
// Description : Self-checking bench for seq_frame_tx: frame-level reference
//               model, literal frame checks and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_frame_tx;

  localparam int DATA_W    = 8;
  localparam int PRE_LEN   = 3;
  localparam int GUARD_LEN = 3;
  localparam int FRAME     = PRE_LEN + DATA_W + GUARD_LEN;

  logic              clk      = 1'b0;
  logic              reset    = 1'b1;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data  = '0;
  logic              in_ready;
  logic              bit_out;
  logic              bit_en;
  logic              busy;
  logic              done;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_on      = 1'b0;

  // Reference model: position within the current frame (-1 = idle).
  int               pos    = -1;
  bit               m_done = 1'b0;
  bit               fr[FRAME];
  logic [PRE_LEN-1:0] pre_v = 3'b101;

  seq_frame_tx #(
    .DATA_W    (DATA_W),
    .PRE_LEN   (PRE_LEN),
    .PREAMBLE  (3'b101),
    .GUARD_LEN (GUARD_LEN)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .bit_out  (bit_out),
    .bit_en   (bit_en),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Frame-level model: a frame is the preamble, the payload MSB first and
  // GUARD_LEN zeros; a word is taken whenever the model is idle.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pos    = -1;
      m_done = 1'b0;
    end else if (pos < 0) begin
      m_done = 1'b0;
      if (in_valid) begin
        for (int i = 0; i < PRE_LEN; i++)   fr[i] = pre_v[PRE_LEN-1-i];
        for (int i = 0; i < DATA_W; i++)    fr[PRE_LEN+i] = in_data[DATA_W-1-i];
        for (int i = 0; i < GUARD_LEN; i++) fr[PRE_LEN+DATA_W+i] = 1'b0;
        pos = 0;
      end
    end else if (pos == FRAME - 1) begin
      pos    = -1;
      m_done = 1'b1;
    end else begin
      pos    = pos + 1;
      m_done = 1'b0;
    end
  end

  // Compare every cycle against the model.
  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      check("m_bit_en",   bit_en,   pos >= 0);
      check("m_bit_out",  bit_out,  (pos >= 0) ? fr[pos] : 1'b0);
      check("m_busy",     busy,     pos >= 0);
      check("m_in_ready", in_ready, pos < 0);
      check("m_done",     done,     m_done);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Offer one word for one cycle; returns 2ns after the accepting edge.
  task automatic send(input logic [DATA_W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  // Literal frame check, entered right after send().
  task automatic frame_lit(input logic [FRAME-1:0] exp, input string tag);
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) tick();
      check({tag, "_bit"}, bit_out, exp[FRAME-1-k]);
      check({tag, "_en"},  bit_en,  1'b1);
    end
    tick();
    check({tag, "_done"},  done,     1'b1);
    check({tag, "_en0"},   bit_en,   1'b0);
    check({tag, "_ready"}, in_ready, 1'b1);
  endtask

  initial begin : stim
    int acc[$];
    logic [2:0] hist;
    int pulses;
    int pulse_at;

    // Reset values before any clock edge.
    #2;
    check("rst_bit_out", bit_out,  1'b0);
    check("rst_bit_en",  bit_en,   1'b0);
    check("rst_busy",    busy,     1'b0);
    check("rst_done",    done,     1'b0);
    check("rst_ready",   in_ready, 1'b1);
    tick();
    tick();
    reset  = 1'b0;
    chk_on = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_en",    bit_en,   1'b0);
      check("idle_ready", in_ready, 1'b1);
    end

    // Single frame A5.
    send(8'hA5);
    frame_lit(14'b101_10100101_000, "a5");
    tick();

    // Held valid: accepts only when idle, at edges 0, 15, 30.
    in_valid = 1'b1;
    in_data  = 8'h3C;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) acc.push_back(i);
      tick();
    end
    in_valid = 1'b0;
    vectors++;
    if (acc.size() != 3 || acc[0] != 0 || acc[1] != 15 || acc[2] != 30) begin
      miscompares++;
      $display("FAIL held_accepts: got %0d accepts (2nd at %0d) expected 3 at 0,15,30",
               acc.size(), (acc.size() > 1) ? acc[1] : -1);
    end
    for (int i = 0; i < 12; i++) tick();

    // Reset during the third payload bit, then a clean FF frame.
    send(8'h5A);
    for (int i = 0; i < 5; i++) tick();
    #1 reset = 1'b1;
    #1;
    check("mid_rst_en",    bit_en,   1'b0);
    check("mid_rst_busy",  busy,     1'b0);
    check("mid_rst_out",   bit_out,  1'b0);
    check("mid_rst_ready", in_ready, 1'b1);
    tick();
    reset = 1'b0;
    tick();
    send(8'hFF);
    frame_lit(14'b101_11111111_000, "ff");
    tick();

    // Loopback into a "101" history detector: one hit per frame, after the preamble.
    hist   = 3'b000;
    pulses = 0;
    for (int f = 0; f < 3; f++) begin
      pulse_at = -1;
      send(8'h00);
      for (int k = 0; k < FRAME + 2; k++) begin
        if (k > 0) tick();
        hist = {hist[1:0], bit_out};
        if (hist == 3'b101) begin
          pulses++;
          if (pulse_at < 0) pulse_at = k;
        end
      end
      vectors++;
      if (pulse_at != PRE_LEN - 1) begin
        miscompares++;
        $display("FAIL loop_pos: frame %0d hit at %0d expected %0d", f, pulse_at, PRE_LEN - 1);
      end
    end
    vectors++;
    if (pulses != 3) begin
      miscompares++;
      $display("FAIL loop_count: got %0d hits expected 3", pulses);
    end

    // Randomized traffic with occasional resets, checked by the model.
    for (int i = 0; i < 600; i++) begin
      tick();
      in_valid = 1'($urandom_range(0, 1));
      in_data  = DATA_W'($urandom);
      reset    = ($urandom_range(0, 99) == 0);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_frame_tx.md
Name: seq_frame_tx

Overview:
- Serial frame transmitter. It is the source side of the single-bit serial line that our Moore "101" sequence detectors monitor.
- Accepts a parallel data word over a valid/ready handshake and emits one frame on a single bit line, one bit per clk:
  - a fixed preamble (default 101, which the detector flags),
  - then the data word, MSB first,
  - then a zero guard interval that flushes the detector's 3-bit history.
- Sits between the control logic that produces words and the serial line feeding the detector's A input.

Parameters:
- DATA_W, 8, payload width in bits; must be ≥1.
- PRE_LEN, 3, preamble length in bits; must be ≥1.
- PREAMBLE, 3'b101, preamble pattern, PRE_LEN bits wide, sent MSB first.
- GUARD_LEN, 3, number of trailing zero bits; must be ≥1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer offers in_data.
- in_ready  output  1  block can accept a word; equals (state==IDLE).
- in_data  input  DATA_W  payload word; sampled only on handshake.
- bit_out  output  1  serial data bit, registered.
- bit_en  output  1  bit_out carries a frame bit this cycle, registered.
- busy  output  1  frame in progress (state != IDLE).
- done  output  1  one-cycle pulse marking the end of a frame.

Behaviour:
- Reset is asynchronous, active-high, on clock clk:
  - state=IDLE, bit_out=0, bit_en=0, done=0, busy=0, in_ready=1;
  - shift register and counter cleared.
- Handshake:
  - a word is accepted on a rising edge where in_valid && in_ready;
  - in_data is captured into the shift register;
  - in_valid while busy is ignored and nothing is queued;
  - in_valid may be held high indefinitely.
- States, all outputs registered:
  - IDLE: bit_out=0, bit_en=0. On handshake, go to PRE with cnt=0.
  - PRE: bit_out=PREAMBLE[PRE_LEN-1-cnt], bit_en=1. After PRE_LEN cycles, go to DATA with cnt=0.
  - DATA: bit_out=shreg[DATA_W-1], shift left by 1 each cycle, bit_en=1. After DATA_W cycles, go to GUARD with cnt=0.
  - GUARD: bit_out=0, bit_en=1. After GUARD_LEN cycles, go to IDLE.
- done=1 for exactly one cycle: the first IDLE cycle after GUARD, in which bit_en=0.
- Latency and length:
  - first preamble bit appears in the cycle after the accepting edge;
  - a frame occupies exactly PRE_LEN+DATA_W+GUARD_LEN consecutive bit_en=1 cycles.
- Back-to-back frames:
  - in_ready=1 during the done cycle, so a word accepted then starts its preamble the next cycle;
  - minimum gap between frames is one bit_en=0 cycle.
- Counter:
  - width is $clog2 of max(PRE_LEN, DATA_W, GUARD_LEN)+1;
  - compares use cnt==LEN-1;
  - no wrap-around within a phase.
- Reset mid-frame: all outputs drop immediately (asynchronously) to their reset values. The partial frame is abandoned and never resumed.
- Unreachable state encodings recover to IDLE on the next clk.
- No data scrambling. A payload containing 101 also triggers the detector; framing above that is the consumer's job.

Decomposition:
- Shared package seq_frame_pkg holds:
  - typedef of the 2-bit state enum: IDLE, PRE, DATA, GUARD;
  - default PREAMBLE, PRE_LEN and GUARD_LEN constants, shared with the detector testbenches.
- One natural sub-module, seq_piso: a DATA_W-bit parallel-load, MSB-first shift register with load and shift enables.
- FSM and counter stay in seq_frame_tx.

Test Plan:
- Reset check: assert reset with no clock edge → bit_out=0, bit_en=0, busy=0, done=0, in_ready=1. Release reset, then 5 idle cycles → outputs unchanged.
- Single frame, in_data=8'hA5, one handshake:
  - over the next 14 cycles bit_out = 1,0,1, 1,0,1,0,0,1,0,1, 0,0,0 with bit_en=1 throughout;
  - cycle 15: done=1, bit_en=0, in_ready=1.
- Held in_valid, in_data=8'h3C, in_valid held high 40 cycles → accepted at cycle 0 and again in the done cycle (cycle 15). Second preamble starts at cycle 16; never more than one accept per frame.
- Reset mid-frame: assert reset asynchronously during the 3rd DATA bit → bit_en and busy fall without a clock edge. After release, the next handshake with 8'hFF yields a full clean 14-bit frame.
- Loopback to the 101 detector, in_data=8'h00, three frames → detector B pulses exactly once per frame, following the preamble; no pulses during guard or idle.
